// File: rtl/pool2x2_stream_unit.sv
// 2x2 stride-2 max/avg pooling over a row-major CH-channel pixel stream.
// Define POOL_RELU_FUSE_EN to clamp negative pooled results to zero.
module pool2x2_stream_unit #(
  parameter int DATA_W = 8,
  parameter int CH     = 4,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LD = IMG_W / 2;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;
  localparam int EW = DATA_W + 1;

  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_w
    $error("IMG_W must be even and >= 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_h
    $error("IMG_H must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic                 mode_q;
  logic [CH*DATA_W-1:0] h;
  logic [CH*EW-1:0]     lb [LD];
  logic [CH*EW-1:0]     lb_rd;
  logic [CH*EW-1:0]     p_all;
  logic [CH*DATA_W-1:0] r_all;
  logic [LW-1:0]        half;
  logic                 accept;
  logic                 take;
  logic                 col_end;
  logic                 row_end;
  logic                 last_beat;

  logic signed [DATA_W-1:0] a_v, b_v, r_v;
  logic signed [EW-1:0]     p_v, l_v;
  logic signed [EW:0]       s_v;

  assign in_ready   = (state == S_RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign take       = out_valid && out_ready;
  assign col_end    = col == CW'(IMG_W - 1);
  assign row_end    = row == RW'(IMG_H - 1);
  assign last_beat  = col_end && row_end;
  assign half       = LW'(col >> 1);
  assign busy       = state != S_IDLE;
  assign frame_done = (state == S_FLUSH) && take;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && last_beat) state_d = S_FLUSH;
      S_FLUSH: if (take) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pair reduce feeds the line buffer; quad reduce feeds the output.
  always_comb begin
    p_all = '0;
    r_all = '0;
    a_v   = '0;
    b_v   = '0;
    r_v   = '0;
    p_v   = '0;
    l_v   = '0;
    s_v   = '0;
    lb_rd = lb[half];
    for (int c = 0; c < CH; c++) begin
      a_v = h[c*DATA_W +: DATA_W];
      b_v = in_data[c*DATA_W +: DATA_W];
      l_v = lb_rd[c*EW +: EW];
      if (mode_q) begin
        p_v = {a_v[DATA_W-1], a_v} + {b_v[DATA_W-1], b_v};
        s_v = {l_v[EW-1], l_v} + {p_v[EW-1], p_v};
        r_v = DATA_W'(s_v >>> 2);
      end else begin
        p_v = (a_v > b_v) ? {a_v[DATA_W-1], a_v}
                          : {b_v[DATA_W-1], b_v};
        r_v = (l_v > p_v) ? l_v[DATA_W-1:0]
                          : p_v[DATA_W-1:0];
      end
      p_all[c*EW +: EW] = p_v;
`ifdef POOL_RELU_FUSE_EN
      r_all[c*DATA_W +: DATA_W] = r_v[DATA_W-1] ? '0 : r_v;
`else
      r_all[c*DATA_W +: DATA_W] = r_v;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= 1'b0;
      h         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        col    <= '0;
        row    <= '0;
        mode_q <= mode;
      end
      if (take) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (accept) begin
        if (!col[0]) h <= in_data;
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (col[0] && row[0]) begin
          out_valid <= 1'b1;
          out_data  <= r_all;
          out_last  <= last_beat;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) lb[half] <= p_all;
  end

endmodule

// File: tb/tb_pool2x2_stream_unit.sv
// Directed bench for pool2x2_stream_unit: 4x4 frames, 4 channels of int8.
module tb_pool2x2_stream_unit;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic        in_valid, in_ready;
  logic [31:0] in_data, out_data;
  logic        out_valid, out_ready, out_last;
  logic        busy, frame_done;

  always #5 clk = ~clk;

  pool2x2_stream_unit #(
    .DATA_W(8), .CH(4), .IMG_W(4), .IMG_H(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    string       nm;
    bit          md;
    logic [31:0] w0, w1, w2, w3, ex;
  } vec_t;

  vec_t        tbl [9];
  int          total = 0;
  int          bad = 0;
  int          fd_cnt = 0;
  bit          fd_last = 0;
  logic [31:0] qd [$];
  logic        ql [$];
  logic [31:0] fb [16];
  logic [31:0] ex [4];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      qd.push_back(out_data);
      ql.push_back(out_last);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_last = out_valid && out_ready && out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic timeout(string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout", nm);
  endtask

  function automatic logic [31:0] pk(int e);
    return {8'(e - 24), 8'(e - 16), 8'(e - 8), 8'(e)};
  endfunction

  function automatic logic [31:0] relu_w(logic [31:0] x);
    logic [31:0] y;
    y = x;
`ifdef POOL_RELU_FUSE_EN
    for (int b = 0; b < 4; b++)
      if (y[8*b+7]) y[8*b +: 8] = 8'h00;
`endif
    return y;
  endfunction

  task automatic send_beat(logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) timeout("in_ready");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic start_frame(bit md);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode  = md;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_frame(bit md);
    start_frame(md);
    for (int i = 0; i < 16; i++) send_beat(fb[i]);
  endtask

  task automatic check_frame(string nm, int fd0);
    int n;
    n = 0;
    while (fd_cnt == fd0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) timeout({nm, "_frame_done"});
    chk({nm, "_nout"}, qd.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < qd.size()) begin
        chk($sformatf("%s_w%0d", nm, k), qd[k], ex[k]);
        chk($sformatf("%s_last%0d", nm, k), 32'(ql[k]), 32'(k == 3));
      end
    end
    chk({nm, "_fd_cnt"}, fd_cnt - fd0, 1);
    chk({nm, "_fd_with_last"}, 32'(fd_last), 1);
    chk({nm, "_busy"}, 32'(busy), 0);
  endtask

  task automatic raster(bit md);
    for (int i = 0; i < 16; i++) fb[i] = pk(i);
    for (int k = 0; k < 4; k++)
      ex[k] = md ? relu_w(pk(k == 0 ? 2 : k == 1 ? 4 : k == 2 ? 10 : 12))
                 : relu_w(pk(k == 0 ? 5 : k == 1 ? 7 : k == 2 ? 13 : 15));
    qd.delete();
    ql.delete();
  endtask

  initial begin
    int          fd0;
    int          n;
    logic [31:0] w [4];

    tbl[0] = '{"avg_neg", 1'b1, 32'hFFFFFFFF, 32'hFEFEFEFE,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFEFEFEFE};
    tbl[1] = '{"max_neg", 1'b0, 32'hFDFDFDFD, 32'hF9F9F9F9,
               32'hFFFFFFFF, 32'hF7F7F7F7, 32'hFFFFFFFF};
    tbl[2] = '{"max_xch", 1'b0, 32'h8080807F, 32'h80807F80,
               32'h807F8080, 32'h7F808080, 32'h7F7F7F7F};
    tbl[3] = '{"max_one", 1'b0, 32'h80808080, 32'h80808080,
               32'h80808080, 32'h8080807F, 32'h8080807F};
    tbl[4] = '{"max_eq", 1'b0, 32'h05050505, 32'h05050505,
               32'h05050505, 32'h05050505, 32'h05050505};
    tbl[5] = '{"avg_pos", 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F,
               32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F};
    tbl[6] = '{"avg_min", 1'b1, 32'h80808080, 32'h80808080,
               32'h80808080, 32'h80808080, 32'h80808080};
    tbl[7] = '{"avg_mix", 1'b1, 32'h0AFF017F, 32'h14000180,
               32'h1E00017F, 32'h29000080, 32'h19FF00FF};
    tbl[8] = '{"max_mix", 1'b0, 32'h640080FB, 32'h9C008103,
               32'h320082FE, 32'h63FF8303, 32'h64008303};

    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    raster(1'b0);
    fd0 = fd_cnt;
    run_frame(1'b0);
    check_frame("max_raster", fd0);

    raster(1'b1);
    fd0 = fd_cnt;
    run_frame(1'b1);
    check_frame("avg_raster", fd0);

    for (int t = 0; t < 9; t++) begin
      w = '{tbl[t].w0, tbl[t].w1, tbl[t].w2, tbl[t].w3};
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          fb[r*4+c] = w[(r % 2) * 2 + (c % 2)];
      for (int k = 0; k < 4; k++) ex[k] = relu_w(tbl[t].ex);
      qd.delete();
      ql.delete();
      fd0 = fd_cnt;
      run_frame(tbl[t].md);
      check_frame(tbl[t].nm, fd0);
    end

    // Output stall on the first word, plus a start pulse that must be ignored.
    raster(1'b0);
    fd0 = fd_cnt;
    fork
      run_frame(1'b0);
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 100);
        if (!out_valid) timeout("stall_wait");
        out_ready = 1'b0;
        start     = 1'b1;
        mode      = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("stall_data%0d", k), out_data, ex[0]);
          chk($sformatf("stall_valid%0d", k), 32'(out_valid), 1);
          chk($sformatf("stall_in_ready%0d", k), 32'(in_ready), 0);
          @(posedge clk);
          #1;
          start = 1'b0;
        end
        out_ready = 1'b1;
      end
    join
    check_frame("stall", fd0);

    // Abort mid-frame at row 2, then rerun cleanly.
    raster(1'b1);
    fd0 = fd_cnt;
    start_frame(1'b1);
    for (int i = 0; i < 10; i++) send_beat(fb[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    chk("abort_no_fd", fd_cnt - fd0, 0);
    chk("abort_nout", qd.size(), 2);
    raster(1'b1);
    fd0 = fd_cnt;
    run_frame(1'b1);
    check_frame("after_abort", fd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
